// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared speed codes, step-period mapping and clock default for hex display stages
package hex_display_pkg;
    localparam int unsigned CLOCK_FREQ_DEFAULT = 50000000;
    typedef enum logic [1:0] {
        SPEED_FULL    = 2'b00,
        SPEED_1X      = 2'b01,
        SPEED_HALF    = 2'b10,
        SPEED_QUARTER = 2'b11
    } speed_e;
    function automatic int unsigned step_period(input logic [1:0] speed, input int unsigned clock_freq);
        return speed == SPEED_FULL ? 1 :
               speed == SPEED_1X   ? clock_freq :
               speed == SPEED_HALF ? 2 * clock_freq : 4 * clock_freq;
    endfunction
endpackage

// File: rtl/rate_divided_hex_counter_if.sv
// rate_divided_hex_counter_if: control inputs and registered outputs of the hex counter
//   Enable, Speed, Direction, Load, LoadValue : master -> slave
//   Count, Tick                               : slave -> master
interface rate_divided_hex_counter_if;
    logic       Enable;
    logic [1:0] Speed;
    logic       Direction;
    logic       Load;
    logic [3:0] LoadValue;
    logic [3:0] Count;
    logic       Tick;
    modport master (output Enable, Speed, Direction, Load, LoadValue, input Count, Tick);
    modport slave  (input Enable, Speed, Direction, Load, LoadValue, output Count, Tick);
endinterface

// File: rtl/rate_divided_hex_counter_rate_divider.sv
// rate_divider: down-counting step divider with speed-change detection
//   Clock, Reset : clock and synchronous active-high reset
//   i_enable     : divider runs when high
//   i_speed      : step-rate select
//   i_load       : counter load, restarts the period
//   o_step       : one-cycle enable pulse to the counter
module rate_divider
    import hex_display_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = CLOCK_FREQ_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       i_enable,
    input  logic [1:0] i_speed,
    input  logic       i_load,
    output logic       o_step
);
    localparam int RD_W = $clog2(4 * CLOCK_FREQ);
    logic [RD_W-1:0] r_rd;
    logic [1:0]      r_speed_reg;
    logic [RD_W-1:0] w_period_m1;
    logic            w_restart;
    always_comb begin
        w_period_m1 = RD_W'(step_period(i_speed, CLOCK_FREQ) - 1);
        // load or a new speed restarts the period and suppresses this edge's step
        w_restart   = i_load || (i_speed != r_speed_reg);
        o_step      = i_enable && !w_restart && (r_rd == '0);
    end
    always_ff @(posedge Clock) begin
        if (Reset || w_restart) begin
            r_speed_reg <= i_speed;
            r_rd        <= w_period_m1;
        end else if (i_enable) begin
            r_rd <= (r_rd == '0) ? w_period_m1 : r_rd - 1'b1;
        end
    end
endmodule

// File: rtl/rate_divided_hex_counter.sv
// rate_divided_hex_counter: 4-bit up/down hex counter stepped at a selectable divided rate
//   Clock, Reset : clock and synchronous active-high reset
//   bus (slave)  : Enable, Speed, Direction, Load, LoadValue in; registered Count, Tick out
module rate_divided_hex_counter
    import hex_display_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = CLOCK_FREQ_DEFAULT
) (
    input logic                      Clock,
    input logic                      Reset,
    rate_divided_hex_counter_if.slave bus
);
    logic       w_step;
    logic [3:0] r_count;
    logic       r_tick;
    rate_divider #(.CLOCK_FREQ(CLOCK_FREQ)) u_rate_divider (
        .Clock    (Clock),
        .Reset    (Reset),
        .i_enable (bus.Enable),
        .i_speed  (bus.Speed),
        .i_load   (bus.Load),
        .o_step   (w_step)
    );
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count <= 4'h0;
            r_tick  <= 1'b0;
        end else if (bus.Load) begin
            r_count <= bus.LoadValue;
            r_tick  <= 1'b0;
        end else begin
            r_count <= w_step ? (bus.Direction ? r_count + 4'd1 : r_count - 4'd1) : r_count;
            r_tick  <= w_step;
        end
    end
    assign bus.Count = r_count;
    assign bus.Tick  = r_tick;
endmodule

// File: tb/tb_rate_divided_hex_counter.sv
// tb_rate_divided_hex_counter: scoreboard bench for the rate-divided hex counter at CLOCK_FREQ=4
module tb_rate_divided_hex_counter;
    typedef struct {
        int       cyc;
        logic [3:0] cnt;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   base;
    exp_t q[$];
    exp_t e;
    rate_divided_hex_counter_if bus ();
    rate_divided_hex_counter #(.CLOCK_FREQ(4)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.Tick) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_tick at edge %0d count=%h, required no tick", cyc, bus.Count);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.cnt != bus.Count) begin
                    errors++;
                    $display("FAIL tick edge=%0d count=%h, required edge=%0d count=%h", cyc, bus.Count, e.cyc, e.cnt);
                end
            end
        end
    end
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask
    task automatic push(input int edge_no, input logic [3:0] c);
        exp_t x;
        x.cyc = edge_no;
        x.cnt = c;
        q.push_back(x);
    endtask
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask
    task automatic chk_empty(input string name);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s missing tick: %0d pending, first at edge %0d count=%h", name, q.size(), q[0].cyc, q[0].cnt);
            q.delete();
        end
    endtask
    task automatic do_reset(input logic [1:0] spd);
        rst = 1'b1;
        bus.Speed = spd;
        bus.Enable = 1'b1;
        bus.Direction = 1'b1;
        bus.Load = 1'b0;
        wait_cyc(1);
        chk("reset_count", bus.Count, 4'h0);
        chk("reset_tick", {3'b0, bus.Tick}, 4'h0);
        rst = 1'b0;
    endtask
    initial begin
        bus.LoadValue = 4'h0;
        // count up at full rate, wrapping F -> 0
        do_reset(2'b00);
        base = cyc;
        for (int i = 1; i <= 17; i++) push(base + i, 4'(i));
        wait_cyc(17);
        chk_empty("full_rate_up");
        // Speed 01: steps on every 4th enabled edge
        do_reset(2'b01);
        base = cyc;
        push(base + 4, 4'h1);
        push(base + 8, 4'h2);
        push(base + 12, 4'h3);
        wait_cyc(12);
        chk_empty("speed01_steps");
        // load zero then count down at full rate through the 0 -> F wrap
        bus.Load = 1'b1;
        bus.LoadValue = 4'h0;
        bus.Direction = 1'b0;
        bus.Speed = 2'b00;
        wait_cyc(1);
        chk("load_count", bus.Count, 4'h0);
        chk("load_tick", {3'b0, bus.Tick}, 4'h0);
        bus.Load = 1'b0;
        base = cyc;
        push(base + 1, 4'hF);
        push(base + 2, 4'hE);
        push(base + 3, 4'hD);
        wait_cyc(3);
        bus.Enable = 1'b0;
        wait_cyc(3);
        chk("freeze_count", bus.Count, 4'hD);
        chk_empty("down_wrap");
        // enable drop mid-period freezes the divider
        do_reset(2'b01);
        wait_cyc(2);
        bus.Enable = 1'b0;
        wait_cyc(5);
        chk("paused_count", bus.Count, 4'h0);
        bus.Enable = 1'b1;
        base = cyc;
        push(base + 2, 4'h1);
        wait_cyc(2);
        chk_empty("enable_resume");
        // speed change 01 -> 11 at edge 2 restarts a 16-cycle period
        do_reset(2'b01);
        base = cyc;
        wait_cyc(1);
        bus.Speed = 2'b11;
        push(base + 18, 4'h1);
        wait_cyc(16);
        chk("speed_change_hold", bus.Count, 4'h0);
        wait_cyc(1);
        chk_empty("speed_change");
        // reset wins over a simultaneous load
        bus.Load = 1'b1;
        bus.LoadValue = 4'h9;
        bus.Speed = 2'b01;
        wait_cyc(1);
        chk("load9_count", bus.Count, 4'h9);
        rst = 1'b1;
        bus.LoadValue = 4'h5;
        wait_cyc(1);
        chk("reset_over_load_count", bus.Count, 4'h0);
        chk("reset_over_load_tick", {3'b0, bus.Tick}, 4'h0);
        rst = 1'b0;
        bus.Load = 1'b0;
        bus.Direction = 1'b1;
        base = cyc;
        push(base + 4, 4'h1);
        // direction flips mid-period without restarting the divider
        push(base + 8, 4'h0);
        wait_cyc(6);
        bus.Direction = 1'b0;
        wait_cyc(2);
        chk("dir_mid_period_count", bus.Count, 4'h0);
        wait_cyc(2);
        chk_empty("reset_over_load");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rate_divided_hex_counter.md
RATE_DIVIDED_HEX_COUNTER -- requirements
Module: rate_divided_hex_counter

Interface
REQ-001 SHALL have parameter: CLOCK_FREQ, 50000000, input clock cycles per second (benches use 4).
REQ-002 SHALL have port: Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: Enable  input  1  1 = divider runs and count may step; 0 = freeze.
REQ-005 SHALL have port: Speed  input  2  step-rate select.
REQ-006 SHALL have port: Direction  input  1  1 = count up, 0 = count down.
REQ-007 SHALL have port: Load  input  1  synchronous parallel load of LoadValue.
REQ-008 SHALL have port: LoadValue  input  4  value loaded into Count.
REQ-009 SHALL have port: Count  output  4  registered hex digit; drives the downstream 7-segment hex decoder directly.
REQ-010 SHALL have port: Tick  output  1  registered one-cycle pulse, high in the cycle Count holds a freshly stepped value.

Function
REQ-011 Step period P SHALL be: Speed 00 -> 1; 01 -> CLOCK_FREQ; 10 -> 2*CLOCK_FREQ; 11 -> 4*CLOCK_FREQ cycles.
REQ-012 Divider RD SHALL be a down-counter wide enough for 4*CLOCK_FREQ-1, holding values 0..P-1.
REQ-013 Per-edge priority SHALL be: Reset > Load > Speed change > Enable step logic.
REQ-014 Load=1 SHALL set Count=LoadValue and RD=P(Speed)-1, clear Tick, and update the registered speed copy, regardless of Enable.
REQ-015 Speed change (Speed != registered copy SpeedReg) SHALL set SpeedReg=Speed and RD=P(Speed)-1, leave Count unchanged, and clear Tick, regardless of Enable.
REQ-016 Enable=1, no load or speed change, RD==0: Count SHALL step by one in Direction, RD SHALL reload to P-1, and Tick SHALL be 1 the next cycle.
REQ-017 Enable=1, no load or speed change, RD!=0: RD SHALL decrement, Count SHALL hold, and Tick SHALL be 0.
REQ-018 Enable=0 with no load or speed change: RD and Count SHALL hold, and Tick SHALL be 0.
REQ-019 Up-count SHALL wrap 0xF->0x0; down-count SHALL wrap 0x0->0xF; Tick SHALL behave identically at wrap.
REQ-020 Direction SHALL be sampled only on the stepping edge; a Direction change mid-period SHALL NOT reload RD.
REQ-021 With Speed 00 and Enable held high, Count SHALL step on every edge and Tick SHALL stay high continuously.
REQ-022 After reset or reload, with Enable continuously high, the first step SHALL occur on the P-th enabled edge.

Reset
REQ-023 Reset SHALL set Count=0x0, Tick=0, SpeedReg=Speed, and RD=P(Speed)-1 on the same edge.
REQ-024 Reset asserted mid-period or together with Load SHALL override everything; Load is ignored.
REQ-025 No output SHALL depend combinationally on Reset; all outputs SHALL be flops.

Structure
REQ-026 Speed codes and the P-mapping function SHALL live in shared package hex_display_pkg, alongside the CLOCK_FREQ default, for reuse by other display stages.
REQ-027 The divider (RD, reload, speed-change detection) SHALL be sub-module rate_divider, emitting a one-cycle enable pulse to the 4-bit counter logic.
REQ-028 The hex decoder SHALL NOT be instantiated inside this block; it is wired at the board top level.

Verification (CLOCK_FREQ=4)
REQ-029 Reset, Speed=00, Enable=1, Direction=1, 17 edges -> Count 1,2,...,F,0,1; Tick high every cycle after the first edge.
REQ-030 Reset, Speed=01, Enable=1 -> Count steps at edges 4, 8, 12; Tick high exactly one cycle after each.
REQ-031 Load=1 with LoadValue=0x0, then Direction=0, Speed=00 -> Count 0x0, 0xF, 0xE, 0xD on successive edges.
REQ-032 Speed=01, Enable dropped after edge 2 for 5 cycles, then raised -> RD frozen at 1; step occurs on the 2nd enabled edge after resume.
REQ-033 Speed 01->11 at edge 2 -> no step at edge 4; next step at edge 18 (2+16); Count unchanged until then.
REQ-034 Count=0x9, Reset and Load(LoadValue=0x5) asserted together -> Count=0x0, Tick=0, and the next step after CLOCK_FREQ enabled edges at Speed 01.
